pipeline_ctrl: RTL

Central sequencing block for the 5-stage pipeline. Generates load and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Handles three conditions:
- memory stalls from the instruction and data caches, including split-completion tracking;
- load-use hazards;
- taken-branch/jump redirects.

Sits beside the datapath; has no data path of its own.

---
 rtl/pipeline_ctrl_pkg.sv | 24 ++
 rtl/pipeline_ctrl_hazard.sv | 51 +++++
 rtl/pipeline_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing block: memory-wait states
// and the bundle of stage-register load/flush controls.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_BOTH = 2'd1,
    WAIT_I    = 2'd2,
    WAIT_D    = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Combinational stage control: freeze, then redirect, then load-use.
// A squashed ID instruction cannot cause a load-use stall.
module hazard_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  freeze,
  input  logic                  ex_redirect,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output stage_ctrl_t           ctrl
);

  logic rs1_hit;
  logic rs2_hit;
  logic lu_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu_hit  = ex_is_load && (ex_rd != '0)
                && (rs1_hit || rs2_hit);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      freeze: ctrl = '0;
      (!freeze && ex_redirect): begin
        ctrl = '1;
      end
      (!freeze && !ex_redirect && lu_hit): begin
        ctrl.id_ex_load  = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        ctrl.ex_mem_load = 1'b1;
        ctrl.mem_wb_load = 1'b1;
      end
      default: begin
        ctrl.pc_load     = 1'b1;
        ctrl.if_id_load  = 1'b1;
        ctrl.id_ex_load  = 1'b1;
        ctrl.ex_mem_load = 1'b1;
        ctrl.mem_wb_load = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencer: cache-wait FSM plus hazard controls.
// Optional perf counters under PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_req,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  output logic                  imem_req_en,
  output logic                  dmem_req_en,
  output logic                  i_capture,
  output logic                  d_capture,
  output logic                  pc_load,
  output logic                  if_id_load,
  output logic                  id_ex_load,
  output logic                  ex_mem_load,
  output logic                  mem_wb_load,
  output logic                  if_id_flush,
  output logic                  id_ex_flush
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cycles,
  output logic [PERF_W-1:0]     perf_loaduse,
  output logic [PERF_W-1:0]     perf_redirects
`endif
);

  mem_state_e  state;
  mem_state_e  state_n;
  logic        i_pend;
  logic        d_pend;
  logic        i_cap;
  logic        d_cap;
  logic        i_en;
  logic        d_en;
  logic        freeze;
  stage_ctrl_t hz_ctrl;
  stage_ctrl_t ctrl;

  assign i_pend = imem_req && !imem_resp;
  assign d_pend = dmem_req && !dmem_resp;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    i_cap   = 1'b0;
    d_cap   = 1'b0;
    i_en    = 1'b0;
    d_en    = 1'b0;
    unique case (state)
      RUN: begin
        i_en = 1'b1;
        d_en = 1'b1;
        unique case (1'b1)
          (i_pend && d_pend): state_n = WAIT_BOTH;
          (i_pend && !d_pend): begin
            state_n = WAIT_I;
            d_cap   = dmem_req;
          end
          (!i_pend && d_pend): begin
            state_n = WAIT_D;
            i_cap   = imem_req;
          end
          default: state_n = RUN;
        endcase
      end
      WAIT_BOTH: begin
        unique case ({imem_resp, dmem_resp})
          2'b11: state_n = RUN;
          2'b10: begin
            state_n = WAIT_D;
            i_cap   = 1'b1;
          end
          2'b01: begin
            state_n = WAIT_I;
            d_cap   = 1'b1;
          end
          default: state_n = WAIT_BOTH;
        endcase
      end
      WAIT_I: begin
        i_en = 1'b1;
        if (imem_resp) state_n = RUN;
      end
      WAIT_D: begin
        d_en = 1'b1;
        if (dmem_resp) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign freeze = (state_n != RUN);

  hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .freeze      (freeze),
    .ex_redirect (ex_redirect),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ctrl        (hz_ctrl)
  );

  assign ctrl        = rst ? '0 : hz_ctrl;
  assign imem_req_en = !rst && i_en;
  assign dmem_req_en = !rst && d_en;
  assign i_capture   = !rst && i_cap;
  assign d_capture   = !rst && d_cap;

  assign pc_load     = ctrl.pc_load;
  assign if_id_load  = ctrl.if_id_load;
  assign id_ex_load  = ctrl.id_ex_load;
  assign ex_mem_load = ctrl.ex_mem_load;
  assign mem_wb_load = ctrl.mem_wb_load;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  // Only a redirect flushes IF/ID; a lone ID/EX flush is a load-use stall.
  logic redirect_eff;
  logic loaduse_eff;

  assign redirect_eff = ctrl.if_id_flush;
  assign loaduse_eff  = ctrl.id_ex_flush && !ctrl.if_id_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_loaduse      <= '0;
      perf_redirects    <= '0;
    end else begin
      if (freeze && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (loaduse_eff && !(&perf_loaduse))
        perf_loaduse <= perf_loaduse + 1'b1;
      if (redirect_eff && !(&perf_redirects))
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule
